// File: rtl/cpu_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges hazard, cache-miss, branch and
// exception requests into per-stage enables, flush/bubble strobes and a PC-select code.
module cpu_pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hd_stall,
    input  logic             icache_miss,
    input  logic             icache_ready,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    input  logic             branch_taken,
    input  logic             exc_req,
    output logic             pc_en,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_en,
    output logic             bubble_execute,
    output logic             flush_decode,
    output logic             flush_execute,
    output logic             flush_mem,
    output logic [1:0]       pc_sel,
    output logic [2:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] StInit      = 3'd0;
    localparam logic [2:0] StRun       = 3'd1;
    localparam logic [2:0] StDmemWait  = 3'd2;
    localparam logic [2:0] StImemWait  = 3'd3;
    localparam logic [2:0] StRedirect  = 3'd4;

    localparam logic [1:0] PcSeq  = 2'd0;
    localparam logic [1:0] PcBr   = 2'd1;
    localparam logic [1:0] PcTrap = 2'd2;

    localparam logic [3:0] RedirInit = 4'(FLUSH_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             imiss_pend_q, imiss_pend_d;
    logic             resume_redir_q, resume_redir_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic do_exc, do_br, dmiss_now, stall_inc;

    // A miss and its ready in the same cycle is a hit.
    assign dmiss_now = dcache_miss & ~dcache_ready;

    always_comb begin
        pc_en          = 1'b1;
        fetch_en       = 1'b1;
        decode_en      = 1'b1;
        execute_en     = 1'b1;
        mem_en         = 1'b1;
        bubble_execute = 1'b0;
        flush_decode   = 1'b0;
        flush_execute  = 1'b0;
        flush_mem      = 1'b0;
        pc_sel         = PcSeq;
        state_d        = state_q;
        cnt_d          = cnt_q;
        imiss_pend_d   = imiss_pend_q & ~icache_ready;
        resume_redir_d = resume_redir_q;
        do_exc         = 1'b0;
        do_br          = 1'b0;

        case (state_q)
            StInit: begin
                {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b00000;
                state_d = StRun;
            end
            StRun: begin
                if (exc_req) begin
                    do_exc = 1'b1;
                end else if (dmiss_now) begin
                    {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b00000;
                    resume_redir_d = 1'b0;
                    state_d        = StDmemWait;
                end else if (branch_taken) begin
                    do_br = 1'b1;
                end else if (icache_miss && !icache_ready) begin
                    pc_en        = 1'b0;
                    fetch_en     = 1'b0;
                    flush_decode = 1'b1;
                    state_d      = StImemWait;
                end else if (hd_stall) begin
                    pc_en          = 1'b0;
                    fetch_en       = 1'b0;
                    decode_en      = 1'b0;
                    bubble_execute = 1'b1;
                end
            end
            StDmemWait: begin
                // Exceptions are not sampled while the memory stage is frozen.
                if (dcache_ready) begin
                    resume_redir_d = 1'b0;
                    if (imiss_pend_q && !icache_ready) begin
                        state_d = StImemWait;
                    end else if (resume_redir_q) begin
                        state_d = StRedirect;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b00000;
                end
            end
            StImemWait: begin
                if (exc_req) begin
                    do_exc = 1'b1;
                end else if (dmiss_now) begin
                    {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b00000;
                    imiss_pend_d   = ~icache_ready;
                    resume_redir_d = 1'b0;
                    state_d        = StDmemWait;
                end else if (branch_taken) begin
                    do_br = 1'b1;
                end else if (icache_ready) begin
                    state_d = StRun;
                    if (hd_stall) begin
                        pc_en          = 1'b0;
                        fetch_en       = 1'b0;
                        decode_en      = 1'b0;
                        bubble_execute = 1'b1;
                    end
                end else begin
                    pc_en        = 1'b0;
                    fetch_en     = 1'b0;
                    flush_decode = 1'b1;
                end
            end
            StRedirect: begin
                if (exc_req) begin
                    do_exc = 1'b1;
                end else if (dmiss_now) begin
                    // Freeze without consuming a redirect bubble; resume afterwards.
                    {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b00000;
                    resume_redir_d = 1'b1;
                    state_d        = StDmemWait;
                end else if (branch_taken) begin
                    do_br = 1'b1;
                end else begin
                    flush_decode = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b00000;
                state_d = StInit;
            end
        endcase

        if (do_exc || do_br) begin
            flush_decode   = 1'b1;
            flush_execute  = 1'b1;
            flush_mem      = do_exc;
            pc_sel         = do_exc ? PcTrap : PcBr;
            pc_en          = 1'b1;
            imiss_pend_d   = 1'b0;
            resume_redir_d = 1'b0;
            cnt_d          = RedirInit;
            state_d        = (RedirInit != 4'd0) ? StRedirect : StRun;
        end
    end

    // INIT is pipeline start-up, not a stall, so it is not counted.
    assign stall_inc = (state_q != StInit) &&
                       (!decode_en || flush_decode || flush_execute || flush_mem);

    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StInit;
            cnt_q          <= 4'd0;
            imiss_pend_q   <= 1'b0;
            resume_redir_q <= 1'b0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            imiss_pend_q   <= imiss_pend_d;
            resume_redir_q <= resume_redir_d;
            stall_q        <= stall_d;
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Directed bench for cpu_pipeline_ctrl: expected per-cycle outputs are queued as each step
// is driven and popped when the outputs are sampled; a second instance checks saturation.
module tb_cpu_pipeline_ctrl;

    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_HD   = 7'b1000000;
    localparam logic [6:0] I_IM   = 7'b0100000;
    localparam logic [6:0] I_IR   = 7'b0010000;
    localparam logic [6:0] I_DM   = 7'b0001000;
    localparam logic [6:0] I_DR   = 7'b0000100;
    localparam logic [6:0] I_BR   = 7'b0000010;
    localparam logic [6:0] I_EX   = 7'b0000001;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_IMIS = 5'b00111;
    localparam logic [4:0] EN_LU   = 5'b00011;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic hd_stall, icache_miss, icache_ready, dcache_miss, dcache_ready, branch_taken, exc_req;
    logic pc_en, fetch_en, decode_en, execute_en, mem_en, bubble_execute;
    logic flush_decode, flush_execute, flush_mem;
    logic [1:0] pc_sel;
    logic [2:0] ctrl_state;
    logic [15:0] stall_cycles;

    logic s_pc_en, s_fetch_en, s_decode_en, s_execute_en, s_mem_en, s_bubble;
    logic s_fd, s_fe, s_fm;
    logic [1:0] s_pc_sel;
    logic [2:0] s_state;
    logic [3:0] s_stall;

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;
    logic [13:0] exp_q[$];

    always #5 clock = ~clock;

    cpu_pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .hd_stall(hd_stall), .icache_miss(icache_miss),
        .icache_ready(icache_ready), .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .branch_taken(branch_taken), .exc_req(exc_req), .pc_en(pc_en), .fetch_en(fetch_en),
        .decode_en(decode_en), .execute_en(execute_en), .mem_en(mem_en),
        .bubble_execute(bubble_execute), .flush_decode(flush_decode),
        .flush_execute(flush_execute), .flush_mem(flush_mem), .pc_sel(pc_sel),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    cpu_pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .hd_stall(hd_stall), .icache_miss(icache_miss),
        .icache_ready(icache_ready), .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .branch_taken(branch_taken), .exc_req(exc_req), .pc_en(s_pc_en), .fetch_en(s_fetch_en),
        .decode_en(s_decode_en), .execute_en(s_execute_en), .mem_en(s_mem_en),
        .bubble_execute(s_bubble), .flush_decode(s_fd), .flush_execute(s_fe),
        .flush_mem(s_fm), .pc_sel(s_pc_sel), .ctrl_state(s_state), .stall_cycles(s_stall)
    );

    // Drive one cycle of inputs, then check Mealy outputs and both stall counters.
    task automatic step(input string tag, input logic [6:0] in, input logic [4:0] en,
                        input logic bub, input logic [2:0] fl, input logic [1:0] sel,
                        input logic [2:0] st);
        logic [13:0] obs, expv;
        int sat;
        {hd_stall, icache_miss, icache_ready, dcache_miss, dcache_ready, branch_taken,
         exc_req} = in;
        exp_q.push_back({en, bub, fl, sel, st});
        if (!reset) model_cnt = 0;
        #1;
        obs = {pc_en, fetch_en, decode_en, execute_en, mem_en, bubble_execute,
               flush_decode, flush_execute, flush_mem, pc_sel, ctrl_state};
        expv = exp_q.pop_front();
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s ctrl: got %b expected %b", tag, obs, expv);
        end
        tests++;
        assert (stall_cycles === 16'(model_cnt)) else begin
            fails++;
            $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, model_cnt);
        end
        sat = (model_cnt > 15) ? 15 : model_cnt;
        tests++;
        assert (s_stall === 4'(sat)) else begin
            fails++;
            $error("FAIL %s sat_stall_cycles: got %0d expected %0d", tag, s_stall, sat);
        end
        if (reset && st != 3'd0 && (!en[2] || fl != 3'b000)) model_cnt++;
        @(negedge clock);
    endtask

    initial begin
        // Reset and release
        step("reset", I_NONE, EN_NONE, 0, 3'b000, 2'd0, 3'd0);
        reset = 1'b1;
        step("init", I_NONE, EN_NONE, 0, 3'b000, 2'd0, 3'd0);
        step("run", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Load-use
        step("lu", I_HD, EN_LU, 1, 3'b000, 2'd0, 3'd1);
        step("lu_after", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // D-miss, ready on 4th cycle
        step("dm1", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd1);
        step("dm2", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd2);
        step("dm3", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd2);
        step("dm_rdy", I_DM | I_DR, EN_ALL, 0, 3'b000, 2'd0, 3'd2);
        step("dm_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Nested I-miss then D-miss
        step("im1", I_IM, EN_IMIS, 0, 3'b100, 2'd0, 3'd1);
        step("im2", I_IM, EN_IMIS, 0, 3'b100, 2'd0, 3'd3);
        step("nest_dm", I_IM | I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd3);
        step("nest_dw", I_IM | I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd2);
        step("nest_drdy", I_IM | I_DM | I_DR, EN_ALL, 0, 3'b000, 2'd0, 3'd2);
        step("nest_iw", I_IM, EN_IMIS, 0, 3'b100, 2'd0, 3'd3);
        step("nest_irdy", I_IM | I_IR, EN_ALL, 0, 3'b000, 2'd0, 3'd3);
        step("nest_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Branch redirect
        step("br", I_BR, EN_ALL, 0, 3'b110, 2'd1, 3'd1);
        step("br_redir", I_NONE, EN_ALL, 0, 3'b100, 2'd0, 3'd4);
        step("br_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Priority: exception beats D-miss and hazard
        step("prio", I_EX | I_DM | I_HD, EN_ALL, 0, 3'b111, 2'd2, 3'd1);
        step("prio_redir", I_NONE, EN_ALL, 0, 3'b100, 2'd0, 3'd4);
        step("prio_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // D-miss during redirect freezes then resumes it
        step("rd_br", I_BR, EN_ALL, 0, 3'b110, 2'd1, 3'd1);
        step("rd_dm", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd4);
        step("rd_drdy", I_DM | I_DR, EN_ALL, 0, 3'b000, 2'd0, 3'd2);
        step("rd_resume", I_NONE, EN_ALL, 0, 3'b100, 2'd0, 3'd4);
        step("rd_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Exception abandons an I-miss
        step("ie_im", I_IM, EN_IMIS, 0, 3'b100, 2'd0, 3'd1);
        step("ie_exc", I_IM | I_EX, EN_ALL, 0, 3'b111, 2'd2, 3'd3);
        step("ie_redir", I_NONE, EN_ALL, 0, 3'b100, 2'd0, 3'd4);
        step("ie_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Exception ignored in DMEM_WAIT
        step("de_dm", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd1);
        step("de_exc", I_DM | I_EX, EN_NONE, 0, 3'b000, 2'd0, 3'd2);
        step("de_rdy", I_DM | I_DR, EN_ALL, 0, 3'b000, 2'd0, 3'd2);
        step("de_done", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // 20 stall cycles: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            step("sat_lu", I_HD, EN_LU, 1, 3'b000, 2'd0, 3'd1);
        end
        step("sat_end", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);
        // Reset mid-wait
        step("mr_dm", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd1);
        step("mr_dw", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd2);
        reset = 1'b0;
        step("mr_rst", I_DM, EN_NONE, 0, 3'b000, 2'd0, 3'd0);
        reset = 1'b1;
        step("mr_init", I_NONE, EN_NONE, 0, 3'b000, 2'd0, 3'd0);
        step("mr_run", I_NONE, EN_ALL, 0, 3'b000, 2'd0, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_pipeline_ctrl.md
# cpu_pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. It merges the hazard detection unit's load-use stall, I-cache and D-cache miss handshakes, the taken-branch redirect from execute, and exception requests into per-stage enables, bubble/flush strobes and a PC-select code. It sits beside `CPU_HDUnit` and drives every pipeline register's enable and flush input.

## Interface
- `FLUSH_CYCLES`, 2: cycles `flush_decode` stays high after a redirect (fetch latency); legal 1..15.
- `CNT_W`, 16: width of the stall performance counter.

- `clock`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `hd_stall`  in  1  load-use hazard from `CPU_HDUnit` (`stall`), same-cycle.
- `icache_miss`  in  1  fetch missed; held until serviced.
- `icache_ready`  in  1  fetch miss serviced; one-cycle pulse.
- `dcache_miss`  in  1  memory-stage access missed.
- `dcache_ready`  in  1  memory-stage miss serviced; one-cycle pulse.
- `branch_taken`  in  1  taken branch/jump resolved in execute.
- `exc_req`  in  1  exception raised in memory stage.
- `pc_en`, `fetch_en`, `decode_en`, `execute_en`, `mem_en`  out  1 each  pipeline register enables.
- `bubble_execute`  out  1  load a NOP into the execute register.
- `flush_decode`, `flush_execute`, `flush_mem`  out  1 each  clear that stage's register.
- `pc_sel`  out  2  0 = sequential, 1 = branch target, 2 = trap vector.
- `ctrl_state`  out  3  current FSM state (debug).
- `stall_cycles`  out  `CNT_W`  saturating stall/flush cycle count.

## Operation
- The FSM has five states: INIT=0, RUN=1, DMEM_WAIT=2, IMEM_WAIT=3, REDIRECT=4.
- Outputs are Mealy: a function of the state and the current inputs. Default is all enables 1, all strobes 0, `pc_sel`=0.
- Event priority: `exc_req` > `dcache_miss` > `branch_taken` > `icache_miss` > `hd_stall`.
- INIT: all enables 0. Moves to RUN on the first clock after `reset` deasserts.
- RUN, `exc_req`:
  - `flush_decode`=`flush_execute`=`flush_mem`=1, `pc_sel`=2, `pc_en`=1.
  - Goes to REDIRECT with the counter set to `FLUSH_CYCLES`-1; if that value is 0, stays in RUN.
- RUN, `dcache_miss` without `dcache_ready`: all enables 0 this cycle; go to DMEM_WAIT.
- RUN, `dcache_miss` with `dcache_ready` in the same cycle: treated as a hit, no stall.
- RUN, `branch_taken`: `flush_decode`=`flush_execute`=1, `pc_sel`=1, `pc_en`=1. Goes to REDIRECT under the same rule as `exc_req`.
- RUN, `icache_miss`: `pc_en`=`fetch_en`=0, `flush_decode`=1, later stages run; go to IMEM_WAIT.
- RUN, `hd_stall`: `pc_en`=`fetch_en`=`decode_en`=0, `bubble_execute`=1. Stays in RUN.
- DMEM_WAIT:
  - All enables 0 while `dcache_ready`=0.
  - When `dcache_ready`=1, default outputs that cycle, then go to IMEM_WAIT if `imiss_pend` is set, else RUN.
  - `exc_req` is not sampled in this state.
- IMEM_WAIT:
  - `pc_en`=`fetch_en`=0 and `flush_decode`=1 until `icache_ready`, then go to RUN.
  - `dcache_miss` here sets `imiss_pend` and enters DMEM_WAIT.
  - `branch_taken` or `exc_req` here abandons the miss (clears pending) and acts exactly as in RUN.
- `imiss_pend` is cleared when `icache_ready` is seen, including while in DMEM_WAIT.
- REDIRECT:
  - `flush_decode`=1, `hd_stall` ignored, counter decrements each cycle; at 0, go to RUN.
  - `exc_req` or `branch_taken` restarts the redirect as in RUN.
  - `dcache_miss` freezes the pipe: go to DMEM_WAIT and resume REDIRECT afterwards with the counter preserved.
- `stall_cycles` increments on any cycle where `decode_en`=0 or any flush is high. It saturates at all-ones and never wraps.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - State INIT, counter 0, `imiss_pend`=0, `stall_cycles`=0.
  - All enables 0, all strobes 0, `pc_sel`=0.
- Stall and flush responses take effect in the same cycle as the request (zero latency); state changes take effect at the next rising edge.
- Exiting DMEM_WAIT costs one cycle: the ready cycle itself.
- A redirect costs exactly `FLUSH_CYCLES` decode bubbles.
- Reset asserted mid-wait or mid-redirect: returns to INIT immediately; the pending miss is dropped.

## Test plan
- Reset release: `reset` 0→1 → `ctrl_state`=0 for one cycle, then 1; all enables 1; `stall_cycles`=0.
- Load-use: `hd_stall`=1 for one cycle in RUN → `fetch_en`=`decode_en`=0, `bubble_execute`=1 that cycle; `stall_cycles`=1.
- D-miss: `dcache_miss` held, `dcache_ready` pulsed on the 4th cycle → enables 0 for 3 cycles and 1 on the ready cycle; state 2→1.
- Nested miss: `icache_miss`, then `dcache_miss` two cycles later, no `icache_ready` → DMEM_WAIT, then IMEM_WAIT after `dcache_ready`, then RUN after `icache_ready`.
- Branch with `FLUSH_CYCLES`=2: `branch_taken` pulse → `pc_sel`=1 and `flush_execute`=1 for one cycle, `flush_decode`=1 for 2 cycles, back in RUN.
- Priority and saturation:
  - `exc_req`, `dcache_miss` and `hd_stall` in the same cycle → `pc_sel`=2, all three flushes high, no freeze.
  - With `CNT_W`=4, 20 stall cycles → `stall_cycles`=15.
